// File: rtl/memory_access_stage.sv
// Memory stage plus MEM/WB register.
// Issues loads/stores on a ready-handshake data bus, lane-aligns store data,
// right-justifies load data, stalls upstream while the bus is busy and aborts
// a hung access after TIMEOUT wait cycles.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of forcing them to natural alignment.
module memory_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [2:0]  LoadTypeW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        BusErrW
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_load, is_store, access;
  size_e       size;
  logic [1:0]  off, off_eff;
  logic        misalign;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes, rdata_shift;
  logic        req, stall, capture, bus_err_d;

  assign is_load  = (ResultSrcM == 2'b01);
  assign is_store = MemWriteM;
  assign access   = is_load | is_store;
  assign off      = ALUResultM[1:0];

  // Access size from the store type for stores, otherwise from the load type
  always_comb begin
    size = SzWord;
    if (is_store) begin
      unique case (StoreTypeM)
        2'b00:   size = SzByte;
        2'b01:   size = SzHalf;
        default: size = SzWord;
      endcase
    end else begin
      unique case (LoadTypeM)
        3'b000, 3'b011: size = SzByte;
        3'b001, 3'b100: size = SzHalf;
        default:        size = SzWord;
      endcase
    end
  end

  // Natural alignment of the offset and optional misalignment detection
  always_comb begin
    unique case (size)
      SzByte:  off_eff = off;
      SzHalf:  off_eff = {off[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = ((size == SzHalf) && off[0]) || ((size == SzWord) && (off != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Store byte enables and lane-replicated write data; loads read the whole word
  always_comb begin
    be_lanes    = 4'b1111;
    wdata_lanes = '0;
    if (is_store) begin
      unique case (size)
        SzByte: begin
          be_lanes    = 4'b0001 << off_eff;
          wdata_lanes = {4{WriteDataM[7:0]}};
        end
        SzHalf: begin
          be_lanes    = 4'b0011 << off_eff;
          wdata_lanes = {2{WriteDataM[15:0]}};
        end
        default: begin
          be_lanes    = 4'b1111;
          wdata_lanes = WriteDataM;
        end
      endcase
    end
  end

  // Move the addressed byte/halfword down to bit 0; extension happens in WriteBack
  assign rdata_shift = mem_rdata >> {off_eff, 3'b000};

  // Next-state, handshake and capture/bubble decision
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    stall     = 1'b0;
    capture   = 1'b0;
    bus_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && misalign) begin
          bus_err_d = 1'b1;
        end else if (access) begin
          req = 1'b1;
          if (mem_ready) begin
            capture = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = 8'd1;
            state_d = StWait;
          end
        end else begin
          capture = 1'b1;
        end
      end
      StWait: begin
        req = 1'b1;
        if (mem_ready) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          // Abandon the access; the held instruction leaves as a bubble
          req       = 1'b0;
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus and stall outputs are forced low while reset is asserted
  assign mem_req   = rst_n & req;
  assign mem_we    = mem_req & is_store;
  assign mem_be    = mem_req ? be_lanes : 4'b0000;
  assign mem_addr  = mem_req ? {ALUResultM[31:2], 2'b00} : 32'd0;
  assign mem_wdata = mem_we ? wdata_lanes : 32'd0;
  assign StallM    = rst_n & stall;

  // FSM state, wait counter and MEM/WB register (bubble whenever not capturing)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      LoadTypeW  <= '0;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      BusErrW    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      BusErrW <= bus_err_d;
      if (capture) begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        LoadTypeW  <= LoadTypeM;
        RdW        <= RdM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= is_load ? rdata_shift : 32'd0;
        PCPlus4W   <= PCPlus4M;
      end else begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= '0;
        LoadTypeW  <= '0;
        RdW        <= '0;
        ALUResultW <= '0;
        ReadDataW  <= '0;
        PCPlus4W   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: table of zero-wait accesses
// with a W-side scoreboard, plus hand sequences for wait states, timeout,
// misalignment and reset during a wait.
module tb_memory_access_stage;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM, StoreTypeM;
  logic [2:0]  LoadTypeM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        StallM, RegWriteW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [2:0]  LoadTypeW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

  always #5 clk = ~clk;

  memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .LoadTypeW(LoadTypeW), .RdW(RdW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .BusErrW(BusErrW)
  );

  typedef struct {
    logic        rw, mw;
    logic [1:0]  rs;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc, rdata;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdw;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [2:0]  lt;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc;
  } w_t;

  int checks = 0;
  int errors = 0;
  w_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] lt,
    input logic [1:0] st, input logic [4:0] rd, input logic [31:0] alu,
    input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] rdata,
    input logic e_req, input logic e_we, input logic [3:0] e_be,
    input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_rdw);
    vec_t v;
    v.rw = rw; v.mw = mw; v.rs = rs; v.lt = lt; v.st = st; v.rd = rd;
    v.alu = alu; v.wd = wd; v.pc = pc; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_be = e_be;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdw = e_rdw;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RegWriteM = v.rw; MemWriteM = v.mw; ResultSrcM = v.rs; LoadTypeM = v.lt;
    StoreTypeM = v.st; RdM = v.rd; ALUResultM = v.alu; WriteDataM = v.wd;
    PCPlus4M = v.pc; mem_rdata = v.rdata;
  endtask

  task automatic idle_inputs();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; LoadTypeM = 0; StoreTypeM = 0;
    RdM = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_be"}, 32'(mem_be), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_StallM"}, 32'(StallM), 0);
    chk({tag, "_RegWriteW"}, 32'(RegWriteW), 0);
    chk({tag, "_RdW"}, 32'(RdW), 0);
    chk({tag, "_ReadDataW"}, ReadDataW, 0);
    chk({tag, "_BusErrW"}, 32'(BusErrW), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    w_t   w;
    int   n;
    bit   done;

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = mkv(1, 0, 2'b01, 3'b010, 2'b00, 5, 32'h100, 0, 32'h1004, 32'hDEADBEEF,
                  1, 0, 4'hF, 32'h100, 0, 32'hDEADBEEF);
    vecs[1] = mkv(0, 1, 2'b00, 3'b000, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h1008, 32'h0BADF00D,
                  1, 1, 4'hC, 32'h200, 32'hABCDABCD, 0);
    vecs[2] = mkv(0, 1, 2'b00, 3'b000, 2'b00, 0, 32'h301, 32'hFFFFFF55, 32'h100C, 0,
                  1, 1, 4'h2, 32'h300, 32'h55555555, 0);
    vecs[3] = mkv(0, 1, 2'b00, 3'b000, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h1010, 0,
                  1, 1, 4'hF, 32'h400, 32'hCAFEF00D, 0);
    vecs[4] = mkv(1, 0, 2'b01, 3'b011, 2'b00, 6, 32'h502, 0, 32'h1014, 32'h11223344,
                  1, 0, 4'hF, 32'h500, 0, 32'h00001122);
    vecs[5] = mkv(1, 0, 2'b01, 3'b100, 2'b00, 7, 32'h602, 0, 32'h1018, 32'hAABBCCDD,
                  1, 0, 4'hF, 32'h600, 0, 32'h0000AABB);
    vecs[6] = mkv(1, 0, 2'b00, 3'b000, 2'b00, 8, 32'h12345678, 32'hFFFF, 32'h101C, 32'h99999999,
                  0, 0, 4'h0, 0, 0, 0);
    vecs[7] = mkv(1, 0, 2'b10, 3'b000, 2'b00, 1, 32'h0, 0, 32'h44, 32'h1,
                  0, 0, 4'h0, 0, 0, 0);
    vecs[8] = mkv(1, 0, 2'b01, 3'b001, 2'b00, 9, 32'h702, 0, 32'h1020, 32'h80011234,
                  1, 0, 4'hF, 32'h700, 0, 32'h00008001);

    // Zero-wait table: bus side checked combinationally, W side via scoreboard
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      mem_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_StallM", i), 32'(StallM), 0);
      w.rw = vecs[i].rw; w.rs = vecs[i].rs; w.lt = vecs[i].lt; w.rd = vecs[i].rd;
      w.alu = vecs[i].alu; w.rdata = vecs[i].e_rdw; w.pc = vecs[i].pc;
      sb_q.push_back(w);
      @(posedge clk);
      #1;
      w = sb_q.pop_front();
      chk($sformatf("v%0d_RegWriteW", i), 32'(RegWriteW), 32'(w.rw));
      chk($sformatf("v%0d_ResultSrcW", i), 32'(ResultSrcW), 32'(w.rs));
      chk($sformatf("v%0d_LoadTypeW", i), 32'(LoadTypeW), 32'(w.lt));
      chk($sformatf("v%0d_RdW", i), 32'(RdW), 32'(w.rd));
      chk($sformatf("v%0d_ALUResultW", i), ALUResultW, w.alu);
      chk($sformatf("v%0d_ReadDataW", i), ReadDataW, w.rdata);
      chk($sformatf("v%0d_PCPlus4W", i), PCPlus4W, w.pc);
      chk($sformatf("v%0d_BusErrW", i), 32'(BusErrW), 0);
    end

    // lb at offset 3, ready after three wait cycles
    @(negedge clk);
    v = mkv(1, 0, 2'b01, 3'b000, 2'b00, 9, 32'h503, 0, 32'h2000, 32'h80FFFFFF,
            1, 0, 4'hF, 32'h500, 0, 32'h80);
    drive(v);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lbw%0d_StallM", c), 32'(StallM), 1);
      chk($sformatf("lbw%0d_mem_req", c), 32'(mem_req), 1);
      chk($sformatf("lbw%0d_mem_addr", c), mem_addr, 32'h500);
      @(posedge clk);
      #1;
      chk($sformatf("lbw%0d_bubble_RegWriteW", c), 32'(RegWriteW), 0);
      chk($sformatf("lbw%0d_bubble_RdW", c), 32'(RdW), 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    chk("lbw_ready_StallM", 32'(StallM), 0);
    @(posedge clk);
    #1;
    chk("lbw_RegWriteW", 32'(RegWriteW), 1);
    chk("lbw_RdW", 32'(RdW), 9);
    chk("lbw_ReadDataW", ReadDataW, 32'h00000080);

    // Load that never completes: timeout abort
    @(negedge clk);
    v = mkv(1, 0, 2'b01, 3'b010, 2'b00, 4, 32'h800, 0, 32'h3000, 32'h12345678,
            1, 0, 4'hF, 32'h800, 0, 0);
    drive(v);
    mem_ready = 1'b0;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (StallM) begin
        n++;
        @(posedge clk);
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_bound: StallM still high after 100 cycles");
    end
    chk("timeout_stall_cycles", 32'(n), TIMEOUT);
    chk("timeout_mem_req", 32'(mem_req), 0);
    @(posedge clk);
    #1;
    chk("timeout_BusErrW", 32'(BusErrW), 1);
    chk("timeout_RegWriteW", 32'(RegWriteW), 0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("timeout_BusErrW_one_cycle", 32'(BusErrW), 0);

    // Misaligned lw at 0x102
    @(negedge clk);
    v = mkv(1, 0, 2'b01, 3'b010, 2'b00, 2, 32'h102, 0, 32'h4000, 32'h12345678,
            1, 0, 4'hF, 32'h100, 0, 32'h12345678);
    drive(v);
    mem_ready = 1'b1;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_mem_req", 32'(mem_req), 0);
    chk("mis_StallM", 32'(StallM), 0);
    @(posedge clk);
    #1;
    chk("mis_BusErrW", 32'(BusErrW), 1);
    chk("mis_RegWriteW", 32'(RegWriteW), 0);
`else
    chk("mis_mem_addr", mem_addr, 32'h100);
    chk("mis_mem_be", 32'(mem_be), 32'hF);
    @(posedge clk);
    #1;
    chk("mis_BusErrW", 32'(BusErrW), 0);
    chk("mis_ReadDataW", ReadDataW, 32'h12345678);
`endif

    // Reset asserted while waiting on the bus
    @(negedge clk);
    v = mkv(1, 0, 2'b01, 3'b010, 2'b00, 3, 32'h900, 0, 32'h5000, 0,
            1, 0, 4'hF, 32'h900, 0, 0);
    drive(v);
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("wait_before_reset_StallM", 32'(StallM), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    v = mkv(1, 0, 2'b00, 3'b000, 2'b00, 3, 32'hA5A5, 0, 32'h6000, 0,
            0, 0, 4'h0, 0, 0, 0);
    drive(v);
    mem_ready = 1'b0;
    #1;
    chk("post_rst_StallM", 32'(StallM), 0);
    @(posedge clk);
    #1;
    chk("post_rst_RegWriteW", 32'(RegWriteW), 1);
    chk("post_rst_RdW", 32'(RdW), 3);
    chk("post_rst_ALUResultW", ALUResultW, 32'hA5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
